conv2x_buf: RTL and testbench
=============================

CONV2X_BUF -- requirements
Module: conv2x_buf

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width.
REQ-002 SHALL have parameter DEPTH, default 8: buffer entries; power of 2, at least 2.
REQ-003 SHALL have parameter AFULL, default 6: almost-full threshold, 1..DEPTH.
REQ-004 SHALL have port clk2x  input  1: the 2x clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port rst2x_  input  1: asynchronous active-low reset.
REQ-006 SHALL have port clr2x  input  1: synchronous flush.
REQ-007 SHALL have port sync2x  input  1: write strobe; one word per high cycle.
REQ-008 SHALL have port data2x  input  WIDTH: write data, qualified by sync2x.
REQ-009 SHALL have port out_vld  output  1: out_data holds a valid word.
REQ-010 SHALL have port out_rdy  input  1: consumer accepts the word.
REQ-011 SHALL have port out_data  output  WIDTH: head-of-buffer word.
REQ-012 SHALL have port level  output  log2(DEPTH)+1: current occupancy.
REQ-013 SHALL have port afull  output  1: level >= AFULL.
REQ-014 SHALL have port ovf  output  1: sticky overflow flag.
REQ-015 SHALL have port ovf_clr  input  1: clears ovf.

Function
REQ-016 SHALL define pop as out_vld && out_rdy; out_rdy SHALL be ignored while out_vld=0.
REQ-017 SHALL define push as sync2x && (level<DEPTH || pop); on push, data2x SHALL be written at wr_ptr and wr_ptr SHALL increment.
REQ-018 SHALL, on pop, increment rd_ptr; both pointers SHALL wrap modulo DEPTH.
REQ-019 SHALL update level as level+push-pop each cycle; simultaneous push and pop SHALL leave level unchanged.
REQ-020 SHALL, when sync2x=1 and push=0 (full, no pop), drop data2x, leave pointers and level unchanged, and set ovf.
REQ-021 SHALL drive out_vld = (level!=0) and out_data = mem[rd_ptr] (show-ahead, no extra register).
REQ-022 SHALL have latency of 1 cycle: a word pushed at edge N is visible on out_vld/out_data after edge N; there is no empty bypass.
REQ-023 SHALL keep out_data stable while out_vld=1 and pop=0.
REQ-024 SHALL derive afull combinationally from level.
REQ-025 SHALL clear ovf when ovf_clr=1, except that an overflow in the same cycle SHALL set ovf (set wins).
REQ-026 SHALL, when clr2x=1, zero the pointers, level and ovf at the next edge, with priority over push, pop and overflow; memory contents need not be cleared.
REQ-027 SHALL accept sync2x in consecutive cycles (full clk2x rate), although the upstream source delivers at most one word per two cycles.

Reset
REQ-028 SHALL, on rst2x_=0, asynchronously force wr_ptr, rd_ptr, level and ovf to 0 and all memory entries to 0.
REQ-029 SHALL therefore hold out_vld=0, out_data=0, level=0, afull=0 and ovf=0 during reset.
REQ-030 SHALL accept a push on the first rising edge after rst2x_ deasserts.
REQ-031 SHALL, if reset is asserted mid-operation, discard all buffered words with no partial output.

Structure
REQ-032 SHALL require no shared package; pointer width log2(DEPTH) and level width SHALL be local parameters.
REQ-033 SHALL place storage in one sub-module, conv2x_buf_ram: DEPTH x WIDTH register array with one write port, one asynchronous read port, and async reset.
REQ-034 SHALL keep pointer, level and flag control in conv2x_buf; RTL SHALL be 120-400 lines.

Verification
REQ-035 Reset then push 0x11, 0x22, 0x33 on alternate cycles, out_rdy=1 -> out_data 0x11, 0x22, 0x33 each 1 cycle after its push; level never exceeds 1.
REQ-036 out_rdy=0, push 8 words 0xA0..0xA7 -> level=8, afull=1 from level 6, ovf=0; a 9th push 0xFF -> dropped, ovf=1, level=8; drain -> 0xA0..0xA7 in order.
REQ-037 Full buffer, sync2x=1 and out_rdy=1 in the same cycle -> new word accepted, level stays 8, ovf stays 0.
REQ-038 ovf=1, ovf_clr=1 with a simultaneous overflow -> ovf stays 1; ovf_clr=1 alone on the next cycle -> ovf=0.
REQ-039 level=5, clr2x=1 with sync2x=1 -> next cycle level=0, out_vld=0, ovf=0; push 0x5A afterwards -> out_data=0x5A.
REQ-040 level=4, assert rst2x_=0 asynchronously between edges -> outputs are 0 immediately; after release, the next push 0x3C is the first word output.

Source files
------------

// File: rtl/conv2x_buf_ram.sv
// Storage for the 2x-clock elastic buffer: DEPTH x WIDTH register array with
// one synchronous write port, one asynchronous read port and async reset.
module conv2x_buf_ram #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk2x,
   input  logic                     rst2x_,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Entries are zeroed on reset so the show-ahead output reads 0 while in reset.
   always_ff @(posedge clk2x or negedge rst2x_) begin
      if (!rst2x_) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/conv2x_buf.sv
// Show-ahead elastic buffer in the 2x clock domain: accepts one word per
// sync2x strobe, presents the head word with valid/ready, flags overflow.
module conv2x_buf #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   parameter int AFULL = 6
) (
   input  logic                     clk2x,
   input  logic                     rst2x_,
   input  logic                     clr2x,
   input  logic                     sync2x,
   input  logic [WIDTH-1:0]         data2x,
   output logic                     out_vld,
   input  logic                     out_rdy,
   output logic [WIDTH-1:0]         out_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     afull,
   output logic                     ovf,
   input  logic                     ovf_clr
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             pop;
   logic             push;
   logic             overflow;
   logic             full;

   // A pop frees a slot in the same cycle, so a full buffer still accepts a word.
   assign pop      = out_vld && out_rdy;
   assign full     = (level == LVL_W'(DEPTH));
   assign push     = sync2x && (!full || pop);
   assign overflow = sync2x && !push;

   assign out_vld = (level != '0);
   assign afull   = (level >= LVL_W'(AFULL));

   conv2x_buf_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk2x  (clk2x),
      .rst2x_ (rst2x_),
      .we     (push && !clr2x),
      .waddr  (wr_ptr),
      .wdata  (data2x),
      .raddr  (rd_ptr),
      .rdata  (out_data)
   );

   // Flush outranks everything; otherwise pointers advance independently.
   always_ff @(posedge clk2x or negedge rst2x_) begin
      if (!rst2x_) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (clr2x) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

   // Set wins over ovf_clr when an overflow happens in the clearing cycle.
   always_ff @(posedge clk2x or negedge rst2x_) begin
      if (!rst2x_) begin
         ovf <= 1'b0;
      end else if (clr2x) begin
         ovf <= 1'b0;
      end else if (overflow) begin
         ovf <= 1'b1;
      end else if (ovf_clr) begin
         ovf <= 1'b0;
      end
   end

endmodule

// File: tb/tb_conv2x_buf.sv
// Scoreboard bench for conv2x_buf: stimulus queues expected words, a negedge
// monitor compares every word the buffer hands out.
module tb_conv2x_buf;

   localparam int WIDTH = 8;
   localparam int DEPTH = 8;
   localparam int AFULL = 6;

   logic             clk2x;
   logic             rst2x_;
   logic             clr2x;
   logic             sync2x;
   logic [WIDTH-1:0] data2x;
   logic             out_vld;
   logic             out_rdy;
   logic [WIDTH-1:0] out_data;
   logic [3:0]       level;
   logic             afull;
   logic             ovf;
   logic             ovf_clr;

   int n_tests = 0;
   int n_fails = 0;
   logic [WIDTH-1:0] exp_q [$];

   conv2x_buf #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AFULL (AFULL)
   ) dut (
      .clk2x    (clk2x),
      .rst2x_   (rst2x_),
      .clr2x    (clr2x),
      .sync2x   (sync2x),
      .data2x   (data2x),
      .out_vld  (out_vld),
      .out_rdy  (out_rdy),
      .out_data (out_data),
      .level    (level),
      .afull    (afull),
      .ovf      (ovf),
      .ovf_clr  (ovf_clr)
   );

   initial clk2x = 1'b0;
   always #5 clk2x = ~clk2x;

   // Inputs change 1 time unit after posedge, so at negedge they show what the next edge will see.
   always @(negedge clk2x) begin
      if (rst2x_ && out_vld && out_rdy) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fails++;
            $display("[TB] FAIL unexpected_word: got %02h, expected no word", out_data);
         end else begin
            logic [WIDTH-1:0] exp_word;
            exp_word = exp_q.pop_front();
            if (out_data !== exp_word) begin
               n_fails++;
               $display("[TB] FAIL out_data: got %02h, expected %02h", out_data, exp_word);
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_tests++;
      if (actual !== expected) begin
         n_fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic step();
      @(posedge clk2x);
      #1;
   endtask

   task automatic applyStimulus(input logic sync, input logic [WIDTH-1:0] data, input logic rdy,
                                input logic clr, input logic oclr, input logic accepted);
      sync2x  = sync;
      data2x  = data;
      out_rdy = rdy;
      clr2x   = clr;
      ovf_clr = oclr;
      if (accepted) begin
         exp_q.push_back(data);
      end
      step();
      sync2x  = 1'b0;
      clr2x   = 1'b0;
      ovf_clr = 1'b0;
   endtask

   initial begin
      logic [WIDTH-1:0] words [3];
      words[0] = 8'h11;
      words[1] = 8'h22;
      words[2] = 8'h33;

      rst2x_  = 1'b0;
      clr2x   = 1'b0;
      sync2x  = 1'b0;
      data2x  = '0;
      out_rdy = 1'b0;
      ovf_clr = 1'b0;
      #12;
      checkOutput("reset_out_vld", 32'(out_vld), 0);
      checkOutput("reset_out_data", 32'(out_data), 0);
      checkOutput("reset_level", 32'(level), 0);
      checkOutput("reset_afull", 32'(afull), 0);
      checkOutput("reset_ovf", 32'(ovf), 0);
      #10;
      rst2x_ = 1'b1;
      step();

      // Alternate-cycle pushes with consumer always ready
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, words[i], 1'b1, 1'b0, 1'b0, 1'b1);
         checkOutput("alt_level_after_push", 32'(level), 1);
         checkOutput("alt_out_data", 32'(out_data), 32'(words[i]));
         applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
         checkOutput("alt_level_after_idle", 32'(level), 0);
      end

      // Fill with consumer stalled, then overflow
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b1);
         checkOutput("fill_level", 32'(level), i + 1);
         checkOutput("fill_afull", 32'(afull), (i + 1 >= 6) ? 1 : 0);
         checkOutput("fill_ovf", 32'(ovf), 0);
      end
      applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("ovf_level", 32'(level), 8);
      checkOutput("ovf_set", 32'(ovf), 1);
      checkOutput("ovf_head_kept", 32'(out_data), 32'hA0);

      // Clear coinciding with another overflow keeps ovf, a lone clear drops it
      applyStimulus(1'b1, 8'hFE, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("ovf_set_wins", 32'(ovf), 1);
      checkOutput("ovf_set_wins_level", 32'(level), 8);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("ovf_cleared", 32'(ovf), 0);

      // Full buffer with simultaneous push and pop
      applyStimulus(1'b1, 8'hB0, 1'b1, 1'b0, 1'b0, 1'b1);
      checkOutput("full_pushpop_level", 32'(level), 8);
      checkOutput("full_pushpop_ovf", 32'(ovf), 0);
      checkOutput("full_pushpop_head", 32'(out_data), 32'hA1);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      checkOutput("drain_level", 32'(level), 0);
      checkOutput("drain_out_vld", 32'(out_vld), 0);

      // Flush outranks a simultaneous push
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      end
      checkOutput("preflush_level", 32'(level), 5);
      applyStimulus(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("flush_level", 32'(level), 0);
      checkOutput("flush_out_vld", 32'(out_vld), 0);
      checkOutput("flush_ovf", 32'(ovf), 0);
      applyStimulus(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b1);
      checkOutput("postflush_out_data", 32'(out_data), 32'h5A);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("postflush_level", 32'(level), 0);

      // Asynchronous reset mid-operation discards buffered words
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 8'hD0 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      end
      checkOutput("prereset_level", 32'(level), 4);
      #2;
      rst2x_ = 1'b0;
      #1;
      checkOutput("midreset_out_vld", 32'(out_vld), 0);
      checkOutput("midreset_out_data", 32'(out_data), 0);
      checkOutput("midreset_level", 32'(level), 0);
      checkOutput("midreset_afull", 32'(afull), 0);
      checkOutput("midreset_ovf", 32'(ovf), 0);
      @(negedge clk2x);
      rst2x_ = 1'b1;
      applyStimulus(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1);
      checkOutput("postreset_out_data", 32'(out_data), 32'h3C);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("postreset_level", 32'(level), 0);
      checkOutput("scoreboard_empty", 32'(exp_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
      $finish;
   end

endmodule
